ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with 2-entry skid buffer
//
// Purpose: captures the execute-stage packet (result mux, store data, rd,
// funct3 and control bits) and hands it to the memory stage through a
// valid/ready handshake. A main (output) register plus one skid register
// let In_Ready be decoded purely from registered state, so there is no
// combinational path from Out_Ready or In_Valid to either handshake output.
//
// Ports:
//   CLK, rst_n          clock, asynchronous active-low reset
//   Flush               synchronous flush, beats accept and deliver
//   In_Valid/In_Ready   EX-side handshake
//   ALU_Res, Set_Res,   result sources; Set_En picks Set_Res
//   Set_En
//   Store_Data, Rd,     packet payload from EX
//   Funct3, Reg_Wr,
//   Mem_Rd, Mem_Wr
//   Out_Valid/Out_Ready MEM-side handshake
//   Out_*               registered packet payload to MEM
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            Flush,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [XLEN-1:0] ALU_Res,
    input  logic [XLEN-1:0] Set_Res,
    input  logic            Set_En,
    input  logic [XLEN-1:0] Store_Data,
    input  logic [4:0]      Rd,
    input  logic [2:0]      Funct3,
    input  logic            Reg_Wr,
    input  logic            Mem_Rd,
    input  logic            Mem_Wr,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [XLEN-1:0] Out_Result,
    output logic [XLEN-1:0] Out_Store_Data,
    output logic [4:0]      Out_Rd,
    output logic [2:0]      Out_Funct3,
    output logic            Out_Reg_Wr,
    output logic            Out_Mem_Rd,
    output logic            Out_Mem_Wr
);

    localparam int PW = 2 * XLEN + 5 + 3 + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   pkt_in;
    logic [XLEN-1:0] result_in;
    logic            reg_wr_in;
    logic            accept;
    logic            deliver;

    assign result_in = Set_En ? Set_Res : ALU_Res;
    // x0 is hardwired to zero, so a write to it is dropped here once rather
    // than being filtered again in every later stage.
    assign reg_wr_in = Reg_Wr && (Rd != 5'd0);
    assign pkt_in    = {result_in, Store_Data, Rd, Funct3, reg_wr_in, Mem_Rd, Mem_Wr};

    assign Out_Valid = (state_q != EMPTY);
    assign In_Ready  = (state_q != FULL);
    assign accept    = In_Valid && In_Ready;
    assign deliver   = Out_Valid && Out_Ready;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = pkt_in;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = pkt_in;
                    end else if (accept) begin
                        skid_d  = pkt_in;
                        state_d = FULL;
                    end else if (deliver) begin
                        // main keeps the delivered packet so the outputs hold
                        // their last values while empty
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // In_Ready is low here, so only a delivery can happen
                    if (deliver) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign {Out_Result, Out_Store_Data, Out_Rd, Out_Funct3,
            Out_Reg_Wr, Out_Mem_Rd, Out_Mem_Wr} = main_q;

endmodule
